// File: rtl/yfilter_pkg.sv
// yfilter_pkg: shared type codes, FSM encoding and helpers for yfilter_ctrl
package yfilter_pkg;
  localparam int PB_DEF = 8;
  localparam logic [1:0] TYPE_NONE = 2'd0;
  localparam logic [1:0] TYPE_TOP = 2'd1;
  localparam logic [1:0] TYPE_MID = 2'd2;
  localparam logic [1:0] TYPE_BOT = 2'd3;
  typedef enum logic [2:0] {IDLE, PRIME, RUN, FLUSH, DONE} state_t;
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
endpackage

// File: rtl/line_ram.sv
// line_ram: simple dual-port line buffer, one write port, registered read port
//   clk   clock
//   we    write enable, waddr/wdata write address and data
//   raddr read address; rdata is mem[raddr] one cycle later
import yfilter_pkg::*;
module line_ram #(
  parameter int PB = PB_DEF,
  parameter int MAXW = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PB-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [PB-1:0] rdata
);
  logic [PB-1:0] mem [MAXW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/yfilter_ctrl.sv
// yfilter_ctrl: 3-row vertical window controller feeding a Y filter from a raster pixel stream
//   clk, rst                    clock, synchronous active-high reset
//   i_start, i_width_m1/height  frame start pulse and dimensions minus one
//   i_pix_valid, i_pix          raster input pixel, accepted when o_pix_ready
//   o_pixelset, o_type          {bottom, center, top} window and row type, one cycle after the step
//   o_col1, o_colN              emitted pixel lies in the first / last column
//   o_busy, o_done              frame in progress, one-cycle end-of-frame pulse
//   Define YFILTER_CTRL_MIRROR_EN to replicate the center row at the frame edges instead of zero fill.
import yfilter_pkg::*;
module yfilter_ctrl #(
  parameter int PB = PB_DEF,
  parameter int MAXW = 1024,
  parameter int AW = 10,
  parameter int HW = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [AW-1:0]   i_width_m1,
  input  logic [HW-1:0]   i_height_m1,
  input  logic            i_pix_valid,
  input  logic [PB-1:0]   i_pix,
  output logic            o_pix_ready,
  output logic [3*PB-1:0] o_pixelset,
  output logic [1:0]      o_type,
  output logic            o_col1,
  output logic            o_colN,
  output logic            o_busy,
  output logic            o_done
);
`ifdef YFILTER_CTRL_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif
  localparam logic [1:0] T_TOP = MIRROR ? TYPE_MID : TYPE_TOP;
  localparam logic [1:0] T_BOT = MIRROR ? TYPE_MID : TYPE_BOT;
  state_t state, state_n;
  logic [AW-1:0] wm1, col;
  logic [HW-1:0] hm1, row;
  logic [1:0] widx, csel_q, tsel_q;
  logic tz_q, bz_q;
  logic [PB-1:0] bot_q, ctr, top, bot;
  logic [PB-1:0] rd [3];
  logic start_ok, acc, run_acc, fl, col_end;
  assign start_ok = state == IDLE && i_start && i_height_m1 != '0;
  assign o_pix_ready = state == PRIME || state == RUN;
  assign o_busy = state != IDLE;
  assign acc = i_pix_valid && o_pix_ready;
  assign run_acc = acc && state == RUN;
  assign fl = state == FLUSH;
  assign col_end = col == wm1;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_ok ? PRIME : IDLE;
      PRIME:   state_n = acc && col_end ? RUN : PRIME;
      RUN:     state_n = acc && col_end && row == hm1 ? FLUSH : RUN;
      FLUSH:   state_n = col_end ? DONE : FLUSH;
      default: state_n = IDLE;
    endcase
  end
  // The row being written lives in buffer widx; the two older rows are the
  // other two buffers, so center/top selection is a fixed rotation of widx
  // that also holds during FLUSH because widx advanced at the last row end.
  always_ff @(posedge clk)
    if (rst) begin
      col <= '0;
      row <= '0;
      widx <= '0;
      wm1 <= '0;
      hm1 <= '0;
      o_type <= TYPE_NONE;
      o_col1 <= 1'b0;
      o_colN <= 1'b0;
      o_done <= 1'b0;
      bot_q <= '0;
      tz_q <= 1'b0;
      bz_q <= 1'b0;
      csel_q <= '0;
      tsel_q <= '0;
    end else begin
      if (start_ok) begin
        wm1 <= i_width_m1;
        hm1 <= i_height_m1;
        col <= '0;
        row <= '0;
        widx <= '0;
      end
      if (acc || fl) col <= col_end ? '0 : col + AW'(1);
      if (acc && col_end) begin
        widx <= inc3(widx);
        row <= row + HW'(1);
      end
      o_type <= run_acc ? (row == HW'(1) ? T_TOP : TYPE_MID) : fl ? T_BOT : TYPE_NONE;
      o_col1 <= (run_acc || fl) && col == '0;
      o_colN <= (run_acc || fl) && col_end;
      o_done <= state == DONE;
      bot_q <= run_acc ? i_pix : '0;
      tz_q <= run_acc && row == HW'(1);
      bz_q <= fl;
      csel_q <= inc3(inc3(widx));
      tsel_q <= inc3(widx);
    end
  for (genvar i = 0; i < 3; i++) begin : g_lb
    line_ram #(.PB(PB), .MAXW(MAXW), .AW(AW)) u_ram (
      .clk(clk),
      .we(acc && widx == 2'(i)),
      .waddr(col),
      .wdata(i_pix),
      .raddr(col),
      .rdata(rd[i])
    );
  end
  // RAM read data is already registered, so the window is muxed combinationally
  // and gated by the registered type to stay zero on idle and bubble cycles.
  assign ctr = csel_q == 2'd0 ? rd[0] : csel_q == 2'd1 ? rd[1] : rd[2];
  assign top = tz_q ? (MIRROR ? ctr : '0) : tsel_q == 2'd0 ? rd[0] : tsel_q == 2'd1 ? rd[1] : rd[2];
  assign bot = bz_q ? (MIRROR ? ctr : '0) : bot_q;
  assign o_pixelset = o_type == TYPE_NONE ? '0 : {bot, ctr, top};
endmodule

// File: tb/tb_yfilter_ctrl.sv
// tb_yfilter_ctrl: directed self-checking bench for yfilter_ctrl
module tb_yfilter_ctrl;
  localparam int PB = 8;
  localparam int AW = 10;
  localparam int HW = 11;
`ifdef YFILTER_CTRL_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic [AW-1:0] i_width_m1 = '0;
  logic [HW-1:0] i_height_m1 = '0;
  logic i_pix_valid = 1'b0;
  logic [PB-1:0] i_pix = '0;
  logic o_pix_ready, o_col1, o_colN, o_busy, o_done;
  logic [3*PB-1:0] o_pixelset;
  logic [1:0] o_type;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_em = -1;
  int done_cyc = -1;
  int done_n = 0;
  logic [1:0] q_type [$];
  logic [3*PB-1:0] q_pix [$];
  logic q_c1 [$];
  logic q_cn [$];
  yfilter_ctrl #(.PB(PB), .MAXW(1024), .AW(AW), .HW(HW)) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_width_m1(i_width_m1),
    .i_height_m1(i_height_m1),
    .i_pix_valid(i_pix_valid),
    .i_pix(i_pix),
    .o_pix_ready(o_pix_ready),
    .o_pixelset(o_pixelset),
    .o_type(o_type),
    .o_col1(o_col1),
    .o_colN(o_colN),
    .o_busy(o_busy),
    .o_done(o_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_type != 2'd0) begin
      q_type.push_back(o_type);
      q_pix.push_back(o_pixelset);
      q_c1.push_back(o_col1);
      q_cn.push_back(o_colN);
      last_em = cyc;
    end
    if (o_done) begin
      done_n++;
      done_cyc = cyc;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [PB-1:0] px(input int r, input int c);
    return PB'(16 * r + c);
  endfunction
  task automatic check_idle_outputs(input string tag);
    check({tag, "_type"}, o_type, 0);
    check({tag, "_pix"}, o_pixelset, 0);
    check({tag, "_col1"}, o_col1, 0);
    check({tag, "_colN"}, o_colN, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_ready"}, o_pix_ready, 0);
  endtask
  task automatic run_frame(input int w, input int h, input bit bub);
    bit seen;
    logic [PB-1:0] t, m, b;
    logic [1:0] ty;
    int r, c, n;
    q_type.delete();
    q_pix.delete();
    q_c1.delete();
    q_cn.delete();
    done_n = 0;
    last_em = -1;
    done_cyc = -1;
    i_width_m1 = AW'(w - 1);
    i_height_m1 = HW'(h - 1);
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    check("busy_start", o_busy, 1);
    for (int rr = 0; rr < h; rr++)
      for (int cc = 0; cc < w; cc++) begin
        if (bub) begin
          i_pix_valid = 1'b0;
          i_start = 1'b1;
          i_width_m1 = '0;
          i_height_m1 = HW'(1);
          cycle();
          i_start = 1'b0;
          check("bubble_type", o_type, 0);
        end
        i_pix_valid = 1'b1;
        i_pix = px(rr, cc);
        check("ready", o_pix_ready, 1);
        cycle();
        i_pix_valid = 1'b0;
        if (rr == 0) check("prime_type", o_type, 0);
      end
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      check("flush_ready", o_pix_ready, 0);
      if (o_done) begin
        seen = 1'b1;
        check("busy_end", o_busy, 0);
      end else cycle();
    end
    check("done_seen", seen, 1);
    cycle();
    cycle();
    check("done_pulse", done_n, 1);
    check("done_after_last", done_cyc - last_em, 1);
    check("em_count", q_type.size(), w * h);
    n = q_type.size() < w * h ? q_type.size() : w * h;
    for (int k = 0; k < n; k++) begin
      if (k < w * (h - 1)) begin
        r = k / w + 1;
        c = k % w;
        m = px(r - 1, c);
        b = px(r, c);
        t = r == 1 ? (MIRROR ? m : '0) : px(r - 2, c);
        ty = r == 1 ? (MIRROR ? 2'd2 : 2'd1) : 2'd2;
      end else begin
        c = k - w * (h - 1);
        m = px(h - 1, c);
        t = px(h - 2, c);
        b = MIRROR ? m : '0;
        ty = MIRROR ? 2'd2 : 2'd3;
      end
      check("em_type", q_type[k], ty);
      check("em_pix", q_pix[k], {b, m, t});
      check("em_col1", q_c1[k], c == 0);
      check("em_colN", q_cn[k], c == w - 1);
    end
  endtask
  task automatic spot_4x3();
    check("spot_type", q_type.size() > 2 ? q_type[2] : 2'd0, MIRROR ? 2 : 1);
    check("spot_pix", q_pix.size() > 2 ? q_pix[2] : '0, MIRROR ? 32'h120202 : 32'h120200);
  endtask
  initial begin
    rst = 1'b1;
    repeat (3) cycle();
    check_idle_outputs("reset");
    rst = 1'b0;
    cycle();
    i_width_m1 = AW'(3);
    i_height_m1 = '0;
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    check("h0_busy", o_busy, 0);
    cycle();
    check("h0_ready", o_pix_ready, 0);
    run_frame(4, 3, 1'b0);
    spot_4x3();
    run_frame(4, 3, 1'b1);
    spot_4x3();
    run_frame(1, 2, 1'b0);
    i_width_m1 = AW'(3);
    i_height_m1 = HW'(2);
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_pix_valid = 1'b1;
      i_pix = px(k / 4, k % 4);
      cycle();
    end
    check("mid_run_type", o_type, MIRROR ? 2 : 1);
    i_pix_valid = 1'b0;
    rst = 1'b1;
    cycle();
    check_idle_outputs("mid_rst");
    rst = 1'b0;
    cycle();
    check_idle_outputs("post_rst");
    run_frame(4, 3, 1'b0);
    spot_4x3();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/yfilter_ctrl.md
YFILTER_CTRL -- requirements
Module: yfilter_ctrl

Interface
REQ-001 Parameter PB, default 8, pixel bit width.
REQ-002 Parameter MAXW, default 1024, maximum image width in pixels.
REQ-003 Parameter AW, default 10, column counter and line-buffer address width; MAXW <= 2**AW.
REQ-004 Parameter HW, default 11, row counter width.
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 i_start  in  1  one-cycle pulse that starts a frame; honoured only in IDLE.
REQ-008 i_width_m1  in  AW  image width minus 1; sampled on accepted i_start.
REQ-009 i_height_m1  in  HW  image height minus 1; sampled on accepted i_start.
REQ-010 i_pix_valid  in  1  input pixel valid; raster order.
REQ-011 i_pix  in  PB  input pixel.
REQ-012 o_pix_ready  out  1  block accepts i_pix this cycle.
REQ-013 o_pixelset  out  3*PB  [PB-1:0] top, [2PB-1:PB] center, [3PB-1:2PB] bottom.
REQ-014 o_type  out  2  0 none, 1 top row, 2 middle row, 3 bottom row.
REQ-015 o_col1  out  1  emitted pixel is in column 0.
REQ-016 o_colN  out  1  emitted pixel is in column i_width_m1.
REQ-017 o_busy  out  1  a frame is in progress.
REQ-018 o_done  out  1  one-cycle pulse after the last emitted pixel of a frame.

Function
REQ-019 The FSM SHALL have states IDLE, PRIME, RUN, FLUSH and DONE.
REQ-020 IDLE->PRIME on i_start with i_height_m1 >= 1; with i_height_m1 == 0, i_start SHALL be ignored.
REQ-021 PRIME SHALL accept row 0 into a line buffer with o_type 0, then go to RUN.
REQ-022 RUN SHALL accept rows 1..H-1; each accepted pixel at column c of row r+1 SHALL emit center = row r[c], top = row r-1[c] (0 when r == 0), bottom = accepted pixel, and type 1 when r == 0, else 2.
REQ-023 After the last pixel of row H-1 is accepted, the FSM SHALL enter FLUSH and emit one pixel per cycle, with center = row H-1, top = row H-2, bottom 0, type 3, for i_width_m1+1 cycles; it SHALL then enter DONE for one cycle (o_done = 1) and return to IDLE.
REQ-024 o_pix_ready SHALL be 1 in PRIME and RUN and 0 in IDLE, FLUSH and DONE; a pixel is accepted when i_pix_valid && o_pix_ready.
REQ-025 Outputs SHALL be registered with latency 1: the emission for an accept or FLUSH step at cycle t SHALL appear at cycle t+1. o_type SHALL be 0 in every cycle without an emission, including input bubbles.
REQ-026 Three line buffers SHALL rotate: the write index advances mod 3 at each row end. Reads SHALL be registered (1 cycle) and aligned with the delayed bottom pixel.
REQ-027 The column counter SHALL wrap from i_width_m1 to 0 and increment the row counter. With width 1, o_col1 and o_colN SHALL both be 1.
REQ-028 o_busy SHALL be 1 from the cycle after an accepted i_start through the DONE cycle.

Reset
REQ-029 On rst the FSM SHALL go to IDLE, counters and rotation index SHALL clear, and all outputs SHALL become 0, including mid-frame. Line-buffer contents are not cleared, and the next frame SHALL be unaffected by them.

Configuration
REQ-030 With YFILTER_CTRL_MIRROR_EN defined, the top row SHALL emit type 2 with top = center, and FLUSH SHALL emit type 2 with bottom = center. Without it, behaviour SHALL be per REQ-022/REQ-023 (types 1 and 3, zero-filled).

Structure
REQ-031 Package yfilter_pkg SHALL hold the type codes (TYPE_NONE/TOP/MID/BOT), the FSM state encoding and the default PB.
REQ-032 Sub-module line_ram (simple dual-port, depth MAXW, registered read) SHALL be instantiated three times.

Verification
REQ-033 4x3 frame, pix = 16*row+col, no bubbles -> PRIME shows o_type 0 for 4 cycles; row 1 col 2 accept of 0x12 -> next cycle pixelset {b=0x12, c=0x02, t=0x00}, type 1; type sequence 1x4, 2x4, 3x4; o_done 1 cycle after the last type 3.
REQ-034 Same frame with i_pix_valid low every other cycle -> o_type 0 in each bubble, identical emission sequence, o_pix_ready 0 throughout FLUSH.
REQ-035 Width 1 (i_width_m1 = 0), height 2 -> every emission has o_col1 = o_colN = 1; emissions are one type 1 then one type 3.
REQ-036 rst asserted mid-RUN -> next cycle all outputs 0, state IDLE; a following 4x3 frame matches REQ-033 exactly.
REQ-037 i_start with i_height_m1 = 0 -> o_busy stays 0; i_start during a frame is ignored. With YFILTER_CTRL_MIRROR_EN, REQ-033 stimulus -> top-row type 2 with t = c = 0x02 at col 2.
